// File: rtl/mem_rr_arbiter_pkg.sv
// Shared constants and helpers for the two-port RAM round-robin arbiter.
package mem_rr_arbiter_pkg;

  localparam int unsigned P0    = 0;
  localparam int unsigned P1    = 1;
  localparam int unsigned LcntW = 8;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick2.sv
// Combinational 2-way pick: lock owner first, otherwise the port not granted last.
module mem_rr_arbiter_rr_pick2
  import mem_rr_arbiter_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       lock_own,
  input  logic       lock_force,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (lock_force) begin
      gnt = onehot2(lock_own) & req;
    end else if (&req) begin
      gnt = onehot2(~last);
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one 64-bit RAM between two req/gnt masters, with a
// bounded burst lock so a locking master cannot starve the other port.
module mem_rr_arbiter
  import mem_rr_arbiter_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 65536,
  parameter int unsigned MAX_LOCK = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_p0_req,
  input  logic                        i_p0_lock,
  input  logic                        i_p0_we,
  input  logic [31:0]                 i_p0_addr,
  input  logic [7:0]                  i_p0_be,
  input  logic [63:0]                 i_p0_wdata,
  output logic                        o_p0_gnt,
  output logic                        o_p0_rvalid,
  output logic [63:0]                 o_p0_rdata,
  input  logic                        i_p1_req,
  input  logic                        i_p1_lock,
  input  logic                        i_p1_we,
  input  logic [31:0]                 i_p1_addr,
  input  logic [7:0]                  i_p1_be,
  input  logic [63:0]                 i_p1_wdata,
  output logic                        o_p1_gnt,
  output logic                        o_p1_rvalid,
  output logic [63:0]                 o_p1_rdata,
  output logic [7:0]                  o_mem_we,
  output logic [$clog2(MEM_SIZE)-1:0] o_mem_addr,
  output logic [63:0]                 o_mem_wdata,
  input  logic [63:0]                 i_mem_rdata
);

  localparam int unsigned AW = $clog2(MEM_SIZE);

  logic [1:0]       req, lk, we, gnt;
  logic             last_q, last_d;
  logic             lock_act_q, lock_act_d;
  logic             lock_own_q, lock_own_d;
  logic [LcntW-1:0] lcnt_q, lcnt_d;
  logic [1:0]       rsel_q, rsel_d;
  logic             own_req, other_req, at_limit, lock_force;
  logic             sel, gnt_any, we_sel;
  logic [7:0]       be_sel;
  logic [31:0]      addr_sel;
  logic             unused_addr;

  assign req = {i_p1_req, i_p0_req};
  assign lk  = {i_p1_lock, i_p0_lock};
  assign we  = {i_p1_we, i_p0_we};

  // At the limit with the other port waiting, the lock is ignored and plain
  // round-robin hands the slot over (last always equals the owner here).
  assign own_req    = req[lock_own_q];
  assign other_req  = req[~lock_own_q];
  assign at_limit   = (lcnt_q == LcntW'(MAX_LOCK));
  assign lock_force = lock_act_q & own_req & ~(at_limit & other_req);

  mem_rr_arbiter_rr_pick2 u_pick (
    .req        (req),
    .last       (last_q),
    .lock_own   (lock_own_q),
    .lock_force (lock_force),
    .gnt        (gnt)
  );

  assign o_p0_gnt = gnt[P0];
  assign o_p1_gnt = gnt[P1];
  assign gnt_any  = |gnt;
  assign sel      = gnt[P1];

  assign we_sel      = sel ? i_p1_we    : i_p0_we;
  assign be_sel      = sel ? i_p1_be    : i_p0_be;
  assign addr_sel    = sel ? i_p1_addr  : i_p0_addr;
  assign o_mem_wdata = sel ? i_p1_wdata : i_p0_wdata;
  assign o_mem_addr  = {addr_sel[AW-1:3], 3'b000};
  assign o_mem_we    = {8{gnt_any & we_sel}} & be_sel;
  assign unused_addr = ^{addr_sel[31:AW], addr_sel[2:0]};

  assign rsel_d      = gnt & ~we;
  assign o_p0_rvalid = rsel_q[P0];
  assign o_p1_rvalid = rsel_q[P1];
  assign o_p0_rdata  = i_mem_rdata;
  assign o_p1_rdata  = i_mem_rdata;

  always_comb begin
    last_d     = last_q;
    lock_act_d = 1'b0;
    lock_own_d = lock_own_q;
    lcnt_d     = '0;
    if (gnt_any) begin
      last_d     = sel;
      lock_act_d = lk[sel];
      lock_own_d = sel;
      // Only a grant earned by a lock in force (and renewed) keeps counting.
      if (lock_force && lk[sel]) begin
        lcnt_d = other_req ? lcnt_q + LcntW'(1) : lcnt_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q     <= 1'b1;
      lock_act_q <= 1'b0;
      lock_own_q <= 1'b0;
      lcnt_q     <= '0;
      rsel_q     <= 2'b00;
    end else begin
      last_q     <= last_d;
      lock_act_q <= lock_act_d;
      lock_own_q <= lock_own_d;
      lcnt_q     <= lcnt_d;
      rsel_q     <= rsel_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: RAM model, behavioural arbitration reference, directed and random runs.
module tb_mem_rr_arbiter;

  localparam int unsigned MemSize = 256;
  localparam int unsigned MaxLock = 4;
  localparam int unsigned Aw      = 8;
  localparam int unsigned Words   = MemSize / 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req, lk, we;
  logic [31:0] addr [2];
  logic [7:0]  be [2];
  logic [63:0] wdata [2];
  logic        g0, g1, rv0, rv1;
  logic [63:0] rd0, rd1;
  logic [7:0]  mem_we;
  logic [Aw-1:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.MEM_SIZE(MemSize), .MAX_LOCK(MaxLock)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_p0_req    (req[0]),
    .i_p0_lock   (lk[0]),
    .i_p0_we     (we[0]),
    .i_p0_addr   (addr[0]),
    .i_p0_be     (be[0]),
    .i_p0_wdata  (wdata[0]),
    .o_p0_gnt    (g0),
    .o_p0_rvalid (rv0),
    .o_p0_rdata  (rd0),
    .i_p1_req    (req[1]),
    .i_p1_lock   (lk[1]),
    .i_p1_we     (we[1]),
    .i_p1_addr   (addr[1]),
    .i_p1_be     (be[1]),
    .i_p1_wdata  (wdata[1]),
    .o_p1_gnt    (g1),
    .o_p1_rvalid (rv1),
    .o_p1_rdata  (rd1),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata)
  );

  function automatic logic [63:0] init_word(input int i);
    return {32'hC0DE_0000 | 32'(i), 32'h1000_0000 | 32'(i)};
  endfunction

  // dpram64 stand-in: byte-enabled write-first, registered read
  logic [63:0] ram [Words];
  logic [63:0] ram_nw;
  logic        ram_loaded = 1'b0;

  always_comb begin
    ram_nw = ram[mem_addr[Aw-1:3]];
    for (int b = 0; b < 8; b++) begin
      if (mem_we[b]) ram_nw[b*8 +: 8] = mem_wdata[b*8 +: 8];
    end
  end

  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < int'(Words); i++) ram[i] <= init_word(i);
      ram_loaded <= 1'b1;
    end else begin
      ram[mem_addr[Aw-1:3]] <= ram_nw;
      mem_rdata             <= ram_nw;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  int          m_last, m_owner, m_streak;
  bit          m_locked;
  logic [1:0]  m_rv;
  logic [63:0] m_rdata;
  logic [63:0] mm [Words];
  int          wait_c [2];
  int          max_wait = 0;

  logic [1:0]  obs_gnt, obs_rv;
  logic [7:0]  obs_we;
  logic [Aw-1:0] obs_addr;
  logic [63:0] obs_rdata0, obs_rdata1;

  task automatic model_reset();
    m_last   = 1;
    m_owner  = 0;
    m_streak = 0;
    m_locked = 0;
    m_rv     = 2'b00;
    m_rdata  = '0;
    wait_c[0] = 0;
    wait_c[1] = 0;
  endtask

  task automatic eval_cycle();
    int          win, wd;
    bit          held;
    logic [1:0]  eg;
    logic [63:0] w;
    win  = -1;
    held = 0;
    if (m_locked && req[m_owner]) begin
      if (m_streak == int'(MaxLock) && req[1-m_owner]) win = 1 - m_owner;
      else begin
        win  = m_owner;
        held = 1;
      end
    end else if (req == 2'b11) win = 1 - m_last;
    else if (req[0]) win = 0;
    else if (req[1]) win = 1;
    eg = (win < 0) ? 2'b00 : 2'(1 << win);

    obs_gnt    = {g1, g0};
    obs_rv     = {rv1, rv0};
    obs_we     = mem_we;
    obs_addr   = mem_addr;
    obs_rdata0 = rd0;
    obs_rdata1 = rd1;

    check("gnt", 64'(obs_gnt), 64'(eg));
    check("rvalid", 64'(obs_rv), 64'(m_rv));
    if (m_rv != 2'b00) check("rdata", m_rv[1] ? rd1 : rd0, m_rdata);
    if (win >= 0) begin
      check("mem_addr", 64'(mem_addr), 64'({addr[win][Aw-1:3], 3'b000}));
      check("mem_we", 64'(mem_we), 64'(we[win] ? be[win] : 8'h00));
      if (we[win]) check("mem_wdata", mem_wdata, wdata[win]);
    end else begin
      check("mem_we_idle", 64'(mem_we), 64'(0));
    end

    for (int n = 0; n < 2; n++) begin
      if (req[n] && !obs_gnt[n]) wait_c[n]++;
      else wait_c[n] = 0;
      if (wait_c[n] > max_wait) max_wait = wait_c[n];
    end

    m_rv = 2'b00;
    if (win >= 0) begin
      wd = int'(addr[win][Aw-1:3]);
      if (we[win]) begin
        w = mm[wd];
        for (int b = 0; b < 8; b++) begin
          if (be[win][b]) w[b*8 +: 8] = wdata[win][b*8 +: 8];
        end
        mm[wd] = w;
      end else begin
        m_rv    = 2'(1 << win);
        m_rdata = mm[wd];
      end
      m_last = win;
      if (lk[win]) begin
        m_streak = held ? m_streak + int'(req[1-win]) : 0;
        m_locked = 1;
        m_owner  = win;
      end else begin
        m_locked = 0;
        m_streak = 0;
      end
    end else begin
      m_locked = 0;
      m_streak = 0;
    end
  endtask

  task automatic tick();
    #3;
    eval_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int n, input bit r, input bit l, input bit w,
                          input logic [31:0] a, input logic [7:0] b, input logic [63:0] d);
    req[n]   = r;
    lk[n]    = l;
    we[n]    = w;
    addr[n]  = a;
    be[n]    = b;
    wdata[n] = d;
  endtask

  logic [1:0] alt_g  [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
  logic [1:0] lock_g [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b10};

  initial begin
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0, '0);
    model_reset();
    for (int i = 0; i < int'(Words); i++) mm[i] = init_word(i);

    repeat (3) @(posedge clk);
    #4;
    check("rst_gnt", 64'({g1, g0}), 64'(0));
    check("rst_rvalid", 64'({rv1, rv0}), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Continuous contention without lock alternates, starting with p0
    set_port(0, 1, 0, 0, 32'h0, 8'h00, '0);
    set_port(1, 1, 0, 0, 32'h18, 8'h00, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("alt_gnt", 64'(obs_gnt), 64'(alt_g[k]));
      if (k > 0) check("alt_rv", 64'(obs_rv), 64'(alt_g[k-1]));
    end
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0, '0);
    tick();
    check("alt_rv_tail", 64'(obs_rv), 64'(2'b10));
    check("alt_rdata", obs_rdata1, 64'hC0DE0003_10000003);

    // Lone p0 read of 0x10
    set_port(0, 1, 0, 0, 32'h10, 8'h00, '0);
    tick();
    check("rd_gnt", 64'(obs_gnt), 64'(2'b01));
    check("rd_addr", 64'(obs_addr), 64'h10);
    check("rd_we", 64'(obs_we), 64'(0));
    set_port(0, 0, 0, 0, '0, '0, '0);
    tick();
    check("rd_rv", 64'(obs_rv), 64'(2'b01));
    check("rd_data", obs_rdata0, 64'hC0DE0002_10000002);

    // Partial write then read-back from the other port
    set_port(0, 1, 0, 1, 32'h8, 8'h0F, 64'hDEADBEEF_01234567);
    tick();
    check("wr_gnt", 64'(obs_gnt), 64'(2'b01));
    check("wr_we", 64'(obs_we), 64'h0F);
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 1, 0, 0, 32'h8, 8'h00, '0);
    tick();
    check("wr_rd_gnt", 64'(obs_gnt), 64'(2'b10));
    set_port(1, 0, 0, 0, '0, '0, '0);
    tick();
    check("wr_rd_rv", 64'(obs_rv), 64'(2'b10));
    check("wr_rd_data", obs_rdata1, 64'hC0DE0001_01234567);

    // p0 holds the lock: five p0 grants, one p1 override, then alternation
    set_port(0, 1, 1, 0, 32'h0, 8'h00, '0);
    set_port(1, 1, 0, 0, 32'h20, 8'h00, '0);
    for (int k = 0; k < 6; k++) begin
      tick();
      check("lock_gnt", 64'(obs_gnt), 64'(lock_g[k]));
    end
    lk[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("lock_rr_gnt", 64'(obs_gnt), 64'(alt_g[k]));
    end
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0, '0);
    tick();

    // Reset right after a p1 read grant suppresses its rvalid
    set_port(1, 1, 0, 0, 32'h28, 8'h00, '0);
    #3;
    eval_cycle();
    check("pre_rst_gnt", 64'(obs_gnt), 64'(2'b10));
    #2 rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    set_port(1, 0, 0, 0, '0, '0, '0);
    #3;
    eval_cycle();
    check("rst_drop_rv", 64'(obs_rv), 64'(0));
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_port(0, 1, 0, 0, 32'h30, 8'h00, '0);
    set_port(1, 1, 0, 0, 32'h38, 8'h00, '0);
    tick();
    check("post_rst_gnt", 64'(obs_gnt), 64'(2'b01));
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0, '0);
    tick();

    // Random traffic; fields stay stable while a request waits
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int n = 0; n < 2; n++) begin
        if (!(req[n] && !obs_gnt[n])) begin
          req[n]   = ($urandom_range(0, 99) < 70);
          we[n]    = 1'($urandom);
          addr[n]  = $urandom;
          be[n]    = 8'($urandom);
          wdata[n] = {$urandom, $urandom};
        end
        lk[n] = ($urandom_range(0, 99) < 60);
      end
      tick();
    end
    set_port(0, 0, 0, 0, '0, '0, '0);
    set_port(1, 0, 0, 0, '0, '0, '0);
    tick();
    check("max_wait_bound", 64'((max_wait <= int'(MaxLock) + 1) ? 1 : 0), 64'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
